axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): BASE_ADDR, 64'h0000_0000_8000_0000, first byte address served; DEPTH, 4096, number of 64-bit words; ID_W, 5, AXI ID width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; clock and reset are listed first among the ports: clk input 1, rising-edge clock; arst_n input 1, asynchronous active-low reset.
REQ-003 The block SHALL have these write-address ports: s_awvalid in 1; s_awready out 1; s_awid in ID_W; s_awaddr in 64; s_awlen in 8; s_awsize in 3; s_awburst in 2.
REQ-004 The block SHALL have these write-data and write-response ports: s_wvalid in 1; s_wready out 1; s_wdata in 64; s_wstrb in 8; s_wlast in 1; s_bvalid out 1; s_bready in 1; s_bid out ID_W; s_bresp out 2.
REQ-005 The block SHALL have these read ports: s_arvalid in 1; s_arready out 1; s_arid in ID_W; s_araddr in 64; s_arlen in 8; s_arsize in 3; s_arburst in 2; s_rvalid out 1; s_rready in 1; s_rid out ID_W; s_rdata out 64; s_rresp out 2; s_rlast out 1.
REQ-006 The block SHALL accept and ignore the lock, cache, prot and qos inputs (1, 4, 3 and 4 bits on each of the AW and AR channels).

Function
REQ-007 The block SHALL act as an AXI4 slave over a DEPTH x 64 storage array that is read asynchronously and written on clk; the array SHALL NOT be cleared by reset.
REQ-008 The read path and the write path SHALL be independent FSMs; a read and a write to the same word in the same cycle SHALL return the old data.
REQ-009 A beat is in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH*8; word index = (addr-BASE_ADDR)>>3.
REQ-010 An out-of-range beat SHALL NOT write the array, and SHALL read as 64'h0.
REQ-011 Beat addresses SHALL advance per burst type: FIXED(00) keeps the address; INCR(01) adds 2^size; WRAP(10) adds 2^size and wraps within an aligned window of (len+1)<<size bytes.
REQ-012 Burst type 11 SHALL be treated as INCR; awsize/arsize values greater than 3 SHALL be treated as 3.
REQ-013 Write FSM states SHALL be W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
REQ-014 s_awready SHALL be 1 only in W_IDLE; on an AW handshake the FSM SHALL latch id, addr, len, size and burst, clear the beat count, and enter W_DATA.
REQ-015 s_wready SHALL be 1 only in W_DATA; each W handshake SHALL write the byte lanes enabled by s_wstrb and advance the address.
REQ-016 The write burst SHALL end on the beat whose count equals awlen, regardless of s_wlast; the FSM SHALL then enter W_RESP.
REQ-017 In W_RESP, s_bvalid=1 and s_bid = the latched id; on the B handshake the FSM SHALL return to W_IDLE.
REQ-018 s_bresp SHALL be DECERR(11) if any beat was out of range, else SLVERR(10) if s_wlast disagreed with the beat count on any beat, else OKAY(00).
REQ-019 Read FSM states SHALL be R_IDLE -> R_DATA -> R_IDLE; s_arready SHALL be 1 only in R_IDLE.
REQ-020 On an AR handshake the FSM SHALL latch id, addr, len, size and burst and register beat 0, driving s_rvalid=1 with beat 0 in the following cycle.
REQ-021 On each R handshake that is not the last beat, the next beat SHALL be registered on the same edge, giving one beat per cycle when s_rready is held high.
REQ-022 s_rlast SHALL be 1 when the beat count equals arlen; s_rresp SHALL be DECERR for an out-of-range beat, else OKAY; s_rid = the latched id.
REQ-023 All R and B outputs SHALL hold stable while valid is high and ready is low.
REQ-024 After the final R handshake the FSM SHALL return to R_IDLE, with s_arready=1 in the next cycle.
REQ-025 Latency SHALL be: AW handshake at cycle T -> s_wready=1 at T+1; last W beat at T -> s_bvalid at T+1; AR at T -> s_rvalid at T+1.

Reset
REQ-026 While arst_n=0, all outputs SHALL be 0 (ready, valid, id, data, resp, last) and both FSMs SHALL be idle.
REQ-027 Assertion of arst_n SHALL take effect immediately, without waiting for a clock edge.
REQ-028 s_awready and s_arready SHALL become 1 on the first clk edge after arst_n deasserts.
REQ-029 Reset asserted during a burst SHALL abandon that burst with no response issued; array words already written SHALL be retained.

Verification
REQ-030 INCR write: awaddr=0x8000_0000, len=3, size=3, data 0x11..0x44, wstrb=FF, then INCR read of the same burst -> bresp=00; rdata 0x11,0x22,0x33,0x44 on consecutive cycles; rlast on beat 3; rid=awid.
REQ-031 WRAP read: araddr=0x8000_0010, len=3, size=3 -> beats read words 2,3,0,1.
REQ-032 Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with wstrb=0x0F, then read -> 0xFFFF_FFFF_0000_0000.
REQ-033 Out of range: write at 0x7FFF_FFF8 -> bresp=11 and no array change; read at BASE_ADDR+DEPTH*8 -> rdata=0, rresp=11.
REQ-034 Backpressure and wlast error: s_rready toggled every cycle during a len=7 read -> all 8 beats delivered in order and held stable while stalled; a len=1 write with s_wlast on beat 0 -> bresp=10.
REQ-035 Reset mid-operation: arst_n pulsed low during W_DATA -> all outputs 0 immediately; s_awready=1 on the first edge after release; previously written words retained.

Source files
------------

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave over a DEPTH x 64-bit array with independent read and write FSMs
module axi_mem_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          ID_W      = 5
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [ID_W-1:0] s_awid,
  input  logic [63:0]     s_awaddr,
  input  logic [7:0]      s_awlen,
  input  logic [2:0]      s_awsize,
  input  logic [1:0]      s_awburst,
  input  logic            s_awlock,
  input  logic [3:0]      s_awcache,
  input  logic [2:0]      s_awprot,
  input  logic [3:0]      s_awqos,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [63:0]     s_wdata,
  input  logic [7:0]      s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [ID_W-1:0] s_bid,
  output logic [1:0]      s_bresp,
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [ID_W-1:0] s_arid,
  input  logic [63:0]     s_araddr,
  input  logic [7:0]      s_arlen,
  input  logic [2:0]      s_arsize,
  input  logic [1:0]      s_arburst,
  input  logic            s_arlock,
  input  logic [3:0]      s_arcache,
  input  logic [2:0]      s_arprot,
  input  logic [3:0]      s_arqos,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [ID_W-1:0] s_rid,
  output logic [63:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic            s_rlast
);
  localparam int          AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [63:0] LIMIT = 64'(DEPTH) << 3;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [63:0]     r_mem [DEPTH];
  w_state_t        r_wstate;
  logic            r_awready, r_wready, r_bvalid, r_wdec, r_wslv;
  logic [ID_W-1:0] r_bid;
  logic [1:0]      r_bresp, r_wburst;
  logic [63:0]     r_waddr;
  logic [7:0]      r_wlen, r_wcnt;
  logic [2:0]      r_wsize;
  r_state_t        r_rstate;
  logic            r_arready, r_rvalid, r_rlast;
  logic [ID_W-1:0] r_rid;
  logic [63:0]     r_rdata, r_raddr;
  logic [1:0]      r_rresp, r_rburst;
  logic [7:0]      r_rlen, r_rcnt;
  logic [2:0]      r_rsize;
  logic            w_whs, w_win, w_wend, w_wdec, w_wslv, w_rin, w_unused;
  logic [AW-1:0]   w_widx;
  logic [63:0]     w_rnext, w_rsel, w_rword;
  // A beat hits the array only inside [BASE_ADDR, BASE_ADDR + DEPTH*8)
  function automatic logic f_in(input logic [63:0] a);
    f_in = a >= BASE_ADDR && (a - BASE_ADDR) < LIMIT;
  endfunction
  function automatic logic [AW-1:0] f_idx(input logic [63:0] a);
    f_idx = AW'((a - BASE_ADDR) >> 3);
  endfunction
  // Sizes above one 64-bit word are folded down to a full word
  function automatic logic [2:0] f_size(input logic [2:0] s);
    f_size = s > 3'd3 ? 3'd3 : s;
  endfunction
  // FIXED holds, WRAP stays inside the (len+1)<<size window, INCR and the reserved type step forward
  function automatic logic [63:0] f_next(input logic [63:0] a, input logic [7:0] len,
                                          input logic [2:0] sz, input logic [1:0] bt);
    logic [63:0] inc, msk;
    inc    = 64'd1 << sz;
    msk    = (({56'd0, len} + 64'd1) << sz) - 64'd1;
    f_next = bt == 2'b00 ? a : bt == 2'b10 ? (a & ~msk) | ((a + inc) & msk) : a + inc;
  endfunction
  assign s_awready = r_awready;
  assign s_wready  = r_wready;
  assign s_bvalid  = r_bvalid;
  assign s_bid     = r_bid;
  assign s_bresp   = r_bresp;
  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rid     = r_rid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;
  assign s_rlast   = r_rlast;
  assign w_unused  = ^{s_awlock, s_awcache, s_awprot, s_awqos, s_arlock, s_arcache, s_arprot, s_arqos};
  assign w_whs     = r_wstate == W_DATA && s_wvalid && r_wready;
  assign w_win     = f_in(r_waddr);
  assign w_widx    = f_idx(r_waddr);
  assign w_wend    = r_wcnt == r_wlen;
  assign w_wdec    = r_wdec | ~w_win;
  assign w_wslv    = r_wslv | (s_wlast != w_wend);
  assign w_rnext   = f_next(r_raddr, r_rlen, r_rsize, r_rburst);
  assign w_rsel    = r_rstate == R_IDLE ? s_araddr : w_rnext;
  assign w_rin     = f_in(w_rsel);
  assign w_rword   = w_rin ? r_mem[f_idx(w_rsel)] : 64'h0;
  // Storage: byte-lane writes on accepted in-range W beats; never cleared by reset
  always_ff @(posedge clk)
    if (w_whs && w_win)
      for (int b = 0; b < 8; b++)
        if (s_wstrb[b]) r_mem[w_widx][8*b +: 8] <= s_wdata[8*b +: 8];
  // Write FSM: address latch, beats counted against awlen, then a single B response
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= 2'b00;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wcnt    <= '0;
      r_wdec    <= 1'b0;
      r_wslv    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (s_awvalid && r_awready) begin
            r_bid     <= s_awid;
            r_waddr   <= s_awaddr;
            r_wlen    <= s_awlen;
            r_wsize   <= f_size(s_awsize);
            r_wburst  <= s_awburst;
            r_wcnt    <= '0;
            r_wdec    <= 1'b0;
            r_wslv    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_whs) begin
            r_waddr <= f_next(r_waddr, r_wlen, r_wsize, r_wburst);
            r_wcnt  <= r_wcnt + 8'd1;
            r_wdec  <= w_wdec;
            r_wslv  <= w_wslv;
            if (w_wend) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= w_wdec ? 2'b11 : w_wslv ? 2'b10 : 2'b00;
              r_wstate <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_bready && r_bvalid) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  // Read FSM: beat 0 registered on AR, each further beat registered on the R handshake it follows
  always_ff @(posedge clk or negedge arst_n)
    if (!arst_n) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
      r_rcnt    <= '0;
    end else if (r_rstate == R_IDLE) begin
      r_arready <= 1'b1;
      if (s_arvalid && r_arready) begin
        r_rid     <= s_arid;
        r_raddr   <= s_araddr;
        r_rlen    <= s_arlen;
        r_rsize   <= f_size(s_arsize);
        r_rburst  <= s_arburst;
        r_rcnt    <= '0;
        r_rdata   <= w_rword;
        r_rresp   <= w_rin ? 2'b00 : 2'b11;
        r_rlast   <= s_arlen == 8'd0;
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
        r_rstate  <= R_DATA;
      end
    end else if (s_rready && r_rvalid) begin
      if (r_rlast) begin
        r_rvalid  <= 1'b0;
        r_arready <= 1'b1;
        r_rstate  <= R_IDLE;
      end else begin
        r_raddr <= w_rnext;
        r_rcnt  <= r_rcnt + 8'd1;
        r_rdata <= w_rword;
        r_rresp <= w_rin ? 2'b00 : 2'b11;
        r_rlast <= r_rcnt + 8'd1 == r_rlen;
      end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed table plus burst sequences for axi_mem_responder
module tb_axi_mem_responder;
  localparam int ID_W = 5;
  logic clk, arst_n;
  logic s_awvalid, s_awready, s_awlock, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_arlock, s_rvalid, s_rready, s_rlast;
  logic [ID_W-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic [7:0]  s_awlen, s_arlen, s_wstrb;
  logic [2:0]  s_awsize, s_arsize, s_awprot, s_arprot;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [3:0]  s_awcache, s_awqos, s_arcache, s_arqos;
  int n_tests = 0, n_fail = 0;
  logic [63:0] wbuf [16];
  logic [63:0] rbuf [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];
  logic [ID_W-1:0] rid_got;
  int rcycles;
  logic [1:0] resp;
  logic [ID_W-1:0] bid;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;
  vec_t tv [14];

  axi_mem_responder dut (
    .clk(clk), .arst_n(arst_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock),
    .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
    .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no handshake within bound, expected one", nm);
  endtask

  task automatic chk_rst(input string nm);
    chk({nm, "_ctrl"}, 64'({s_awready, s_wready, s_bvalid, s_bid, s_bresp,
                            s_arready, s_rvalid, s_rid, s_rresp, s_rlast}), 64'd0);
    chk({nm, "_rdata"}, s_rdata, 64'd0);
  endtask

  task automatic write_burst(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [ID_W-1:0] id, input logic [7:0] strb, input int last_at,
                             output logic [1:0] bresp_o, output logic [ID_W-1:0] bid_o);
    int n;
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = addr; s_awlen = len; s_awsize = 3'd3; s_awburst = burst; s_awid = id;
    n = 0;
    while (!s_awready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("aw_wait");
    @(negedge clk);
    s_awvalid = 1'b0;
    chk("wready_lat", 64'(s_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      s_wvalid = 1'b1; s_wdata = wbuf[i]; s_wstrb = strb; s_wlast = (i == last_at);
      n = 0;
      while (!s_wready && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) tmo("w_wait");
      @(negedge clk);
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    chk("bvalid_lat", 64'(s_bvalid), 64'd1);
    s_bready = 1'b1;
    n = 0;
    while (!s_bvalid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("b_wait");
    bresp_o = s_bresp; bid_o = s_bid;
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  task automatic read_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [ID_W-1:0] id, input logic toggle);
    int n, got, cyc;
    logic stalled;
    logic [63:0] held;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arid = id;
    n = 0;
    while (!s_arready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) tmo("ar_wait");
    @(negedge clk);
    s_arvalid = 1'b0;
    chk("rvalid_lat", 64'(s_rvalid), 64'd1);
    got = 0; cyc = 0; stalled = 1'b0; held = '0; s_rready = 1'b0;
    while (got <= int'(len) && cyc < 200) begin
      if (stalled) begin
        chk("r_hold_valid", 64'(s_rvalid), 64'd1);
        chk("r_hold_data", s_rdata, held);
      end
      s_rready = toggle ? ~s_rready : 1'b1;
      if (s_rvalid && s_rready) begin
        rbuf[got] = s_rdata; rrbuf[got] = s_rresp; rlbuf[got] = s_rlast; rid_got = s_rid;
        got++;
      end
      stalled = s_rvalid && !s_rready;
      held = s_rdata;
      @(negedge clk);
      cyc++;
    end
    s_rready = 1'b0;
    if (got <= int'(len)) tmo("r_wait");
    rcycles = cyc;
    chk("arready_after", 64'({s_arready, s_rvalid}), 64'd2);
  endtask

  initial begin
    tv[0]  = '{1'b1, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'h0};
    tv[1]  = '{1'b1, 64'h8000_0100, 64'h0,                   8'h0F, 2'b00, 64'h0};
    tv[2]  = '{1'b0, 64'h8000_0100, 64'h0,                   8'h00, 2'b00, 64'hFFFF_FFFF_0000_0000};
    tv[3]  = '{1'b1, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0};
    tv[4]  = '{1'b1, 64'h7FFF_FFF8, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 2'b11, 64'h0};
    tv[5]  = '{1'b0, 64'h8000_7FF8, 64'h0,                   8'h00, 2'b00, 64'h0123_4567_89AB_CDEF};
    tv[6]  = '{1'b0, 64'h7FFF_FFF8, 64'h0,                   8'h00, 2'b11, 64'h0};
    tv[7]  = '{1'b0, 64'h8000_8000, 64'h0,                   8'h00, 2'b11, 64'h0};
    tv[8]  = '{1'b1, 64'h8000_8000, 64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 2'b11, 64'h0};
    tv[9]  = '{1'b0, 64'h8000_0000, 64'h0,                   8'h00, 2'b00, 64'h11};
    tv[10] = '{1'b1, 64'h8000_0108, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0};
    tv[11] = '{1'b1, 64'h8000_0108, 64'hAAAA_AAAA_AAAA_AAAA, 8'h81, 2'b00, 64'h0};
    tv[12] = '{1'b0, 64'h8000_0108, 64'h0,                   8'h00, 2'b00, 64'hAA22_3344_5566_77AA};
    tv[13] = '{1'b0, 64'h0,         64'h0,                   8'h00, 2'b11, 64'h0};

    arst_n = 1'b0;
    {s_awvalid, s_awlock, s_wvalid, s_wlast, s_bready, s_arvalid, s_arlock, s_rready} = '0;
    s_awid = '0; s_arid = '0; s_awaddr = '0; s_araddr = '0; s_wdata = '0;
    s_awlen = '0; s_arlen = '0; s_wstrb = '0; s_awsize = '0; s_arsize = '0;
    s_awburst = '0; s_arburst = '0; s_awprot = '0; s_arprot = '0;
    s_awcache = '0; s_awqos = '0; s_arcache = '0; s_arqos = '0;
    #22;
    chk_rst("reset");
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 64'({s_awready, s_arready}), 64'd3);

    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    write_burst(64'h8000_0000, 8'd3, 2'b01, 5'd5, 8'hFF, 3, resp, bid);
    chk("incr_bresp", 64'(resp), 64'd0);
    chk("incr_bid", 64'(bid), 64'd5);
    read_burst(64'h8000_0000, 8'd3, 3'd3, 2'b01, 5'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("incr_rdata%0d", i), rbuf[i], 64'h11 * 64'(i + 1));
      chk($sformatf("incr_rlast%0d", i), 64'(rlbuf[i]), 64'(i == 3));
      chk($sformatf("incr_rresp%0d", i), 64'(rrbuf[i]), 64'd0);
    end
    chk("incr_rid", 64'(rid_got), 64'd5);
    chk("incr_consecutive", 64'(rcycles), 64'd4);

    read_burst(64'h8000_0010, 8'd3, 3'd3, 2'b10, 5'd3, 1'b0);
    chk("wrap_b0", rbuf[0], 64'h33);
    chk("wrap_b1", rbuf[1], 64'h44);
    chk("wrap_b2", rbuf[2], 64'h11);
    chk("wrap_b3", rbuf[3], 64'h22);

    read_burst(64'h8000_0000, 8'd1, 3'd3, 2'b11, 5'd1, 1'b0);
    chk("burst11_b1", rbuf[1], 64'h22);
    read_burst(64'h8000_0000, 8'd1, 3'd7, 2'b01, 5'd1, 1'b0);
    chk("size7_b1", rbuf[1], 64'h22);
    read_burst(64'h8000_0000, 8'd1, 3'd2, 2'b01, 5'd1, 1'b0);
    chk("size2_b1", rbuf[1], 64'h11);

    for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    write_burst(64'h8000_0200, 8'd7, 2'b01, 5'd9, 8'hFF, 7, resp, bid);
    chk("bp_bresp", 64'(resp), 64'd0);
    read_burst(64'h8000_0200, 8'd7, 3'd3, 2'b01, 5'd9, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bp_rdata%0d", i), rbuf[i], 64'hC0DE_0000_0000_0000 | 64'(i));
      chk($sformatf("bp_rlast%0d", i), 64'(rlbuf[i]), 64'(i == 7));
    end

    wbuf[0] = 64'hAAA; wbuf[1] = 64'hBBB;
    write_burst(64'h8000_0300, 8'd1, 2'b01, 5'd2, 8'hFF, 0, resp, bid);
    chk("wlast_err_bresp", 64'(resp), 64'd2);
    wbuf[0] = 64'h1; wbuf[1] = 64'h2; wbuf[2] = 64'h3;
    write_burst(64'h8000_0320, 8'd2, 2'b00, 5'd4, 8'hFF, 2, resp, bid);
    chk("fixed_bresp", 64'(resp), 64'd0);
    read_burst(64'h8000_0320, 8'd0, 3'd3, 2'b01, 5'd4, 1'b0);
    chk("fixed_rdata", rbuf[0], 64'h3);

    for (int i = 0; i < 14; i++) begin
      if (tv[i].wr) begin
        wbuf[0] = tv[i].data;
        write_burst(tv[i].addr, 8'd0, 2'b01, 5'(i), tv[i].strb, 0, resp, bid);
        chk($sformatf("tv%0d_bresp", i), 64'(resp), 64'(tv[i].resp));
      end else begin
        read_burst(tv[i].addr, 8'd0, 3'd3, 2'b01, 5'(i), 1'b0);
        chk($sformatf("tv%0d_rdata", i), rbuf[0], tv[i].rdata);
        chk($sformatf("tv%0d_rresp", i), 64'(rrbuf[0]), 64'(tv[i].resp));
      end
    end

    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 64'h8000_0400; s_awlen = 8'd3; s_awsize = 3'd3; s_awburst = 2'b01; s_awid = 5'd7;
    while (!s_awready) @(negedge clk);
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid = 1'b1; s_wdata = 64'hBEEF; s_wstrb = 8'hFF; s_wlast = 1'b0;
    @(negedge clk);
    s_wdata = 64'hDEAD;
    chk("mid_wready", 64'(s_wready), 64'd1);
    #2 arst_n = 1'b0;
    #1 chk_rst("rst_immediate");
    s_wvalid = 1'b0;
    @(negedge clk);
    chk_rst("rst_held");
    arst_n = 1'b1;
    @(negedge clk);
    chk("awready_after_rel", 64'(s_awready), 64'd1);
    read_burst(64'h8000_0400, 8'd0, 3'd3, 2'b01, 5'd1, 1'b0);
    chk("retained_beat", rbuf[0], 64'hBEEF);
    read_burst(64'h8000_0000, 8'd0, 3'd3, 2'b01, 5'd1, 1'b0);
    chk("retained_word0", rbuf[0], 64'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
